// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU.
// It decodes datapath enables from the registered state and counts retired instructions.
module cpu_control_fsm #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op_class,
    input  logic             branch_taken,
    input  logic             halt,
    input  logic             stall,
    output logic             pc_enable,
    output logic             pc_load,
    output logic             ir_enable,
    output logic             r_enable,
    output logic             alu_bus_enable,
    output logic             reg_read,
    output logic             mem_we,
    output logic             halted,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WB = 3'd4,
        S_MEM_WR = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_wait_cnt;
    logic [3:0]       w_wait_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_wait_done;
    logic             w_retire;

    logic w_pc_en, w_pc_ld, w_ir_en, w_rf_en, w_alu_bus, w_rd, w_we, w_halted;

    // A count above the latency can only come from corruption; treat it as finished.
    assign w_wait_done = (r_wait_cnt >= LAT);

    assign w_retire = !stall && ((r_state == S_EXEC)   || (r_state == S_MEM_WB) ||
                                 (r_state == S_MEM_WR) || (r_state == S_BRANCH));

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            S_FETCH: begin
                if (w_wait_done) w_state_next = S_DECODE;
                else             w_wait_next  = r_wait_cnt + 4'd1;
            end
            S_DECODE: begin
                if (halt) begin
                    w_state_next = S_HALT;
                end else begin
                    case (op_class)
                        2'b00:   w_state_next = S_EXEC;
                        2'b01:   w_state_next = S_MEM_RD;
                        2'b10:   w_state_next = S_MEM_WR;
                        default: w_state_next = S_BRANCH;
                    endcase
                end
            end
            S_MEM_RD: begin
                if (w_wait_done) w_state_next = S_MEM_WB;
                else             w_wait_next  = r_wait_cnt + 4'd1;
            end
            S_EXEC, S_MEM_WB, S_MEM_WR, S_BRANCH: w_state_next = S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
        if (w_state_next != r_state) w_wait_next = 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 4'd0;
            r_retired  <= '0;
        end else if (!stall) begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_pc_en   = 1'b0;
        w_pc_ld   = 1'b0;
        w_ir_en   = 1'b0;
        w_rf_en   = 1'b0;
        w_alu_bus = 1'b1;
        w_rd      = 1'b0;
        w_we      = 1'b0;
        w_halted  = 1'b0;
        case (r_state)
            S_FETCH:  w_ir_en = w_wait_done;
            S_EXEC: begin
                w_pc_en = 1'b1;
                w_rf_en = 1'b1;
            end
            S_MEM_RD: begin
                w_alu_bus = 1'b0;
                w_rd      = 1'b1;
            end
            S_MEM_WB: begin
                w_alu_bus = 1'b0;
                w_rd      = 1'b1;
                w_rf_en   = 1'b1;
                w_pc_en   = 1'b1;
            end
            S_MEM_WR: begin
                w_alu_bus = 1'b0;
                w_we      = 1'b1;
                w_pc_en   = 1'b1;
            end
            S_BRANCH: begin
                w_pc_ld = branch_taken;
                w_pc_en = !branch_taken;
            end
            S_HALT:   w_halted = 1'b1;
            default:  w_ir_en  = 1'b0;
        endcase
    end

    // Stall only suppresses strobes; the bus select and read indicator follow the state.
    assign pc_enable      = w_pc_en & ~stall;
    assign pc_load        = w_pc_ld & ~stall;
    assign ir_enable      = w_ir_en & ~stall;
    assign r_enable       = w_rf_en & ~stall;
    assign mem_we         = w_we    & ~stall;
    assign alu_bus_enable = w_alu_bus;
    assign reg_read       = w_rd;
    assign halted         = w_halted;
    assign state_out      = r_state;
    assign retired_count  = r_retired;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations,
// and the monitor pops and compares them against the selected instance.
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset, reset0;
    logic [1:0]  op_class, op_class0;
    logic        branch_taken, branch_taken0;
    logic        halt, halt0;
    logic        stall, stall0;

    logic        pc_enable, pc_load, ir_enable, r_enable, alu_bus_enable, reg_read, mem_we, halted;
    logic [2:0]  state_out;
    logic [15:0] retired_count;

    logic        pc_enable0, pc_load0, ir_enable0, r_enable0, alu_bus_enable0, reg_read0, mem_we0, halted0;
    logic [2:0]  state_out0;
    logic [3:0]  retired_count0;

    cpu_control_fsm #(.MEM_LATENCY(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .op_class(op_class), .branch_taken(branch_taken),
        .halt(halt), .stall(stall), .pc_enable(pc_enable), .pc_load(pc_load),
        .ir_enable(ir_enable), .r_enable(r_enable), .alu_bus_enable(alu_bus_enable),
        .reg_read(reg_read), .mem_we(mem_we), .halted(halted), .state_out(state_out),
        .retired_count(retired_count)
    );

    cpu_control_fsm #(.MEM_LATENCY(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset0), .op_class(op_class0), .branch_taken(branch_taken0),
        .halt(halt0), .stall(stall0), .pc_enable(pc_enable0), .pc_load(pc_load0),
        .ir_enable(ir_enable0), .r_enable(r_enable0), .alu_bus_enable(alu_bus_enable0),
        .reg_read(reg_read0), .mem_we(mem_we0), .halted(halted0), .state_out(state_out0),
        .retired_count(retired_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable vectors: {pc_enable, pc_load, ir_enable, r_enable, alu_bus_enable, reg_read, mem_we, halted}
    localparam logic [7:0] E_FW   = 8'b0000_1000;
    localparam logic [7:0] E_FIR  = 8'b0010_1000;
    localparam logic [7:0] E_DEC  = 8'b0000_1000;
    localparam logic [7:0] E_EXEC = 8'b1001_1000;
    localparam logic [7:0] E_RD   = 8'b0000_0100;
    localparam logic [7:0] E_WB   = 8'b1001_0100;
    localparam logic [7:0] E_WR   = 8'b1000_0010;
    localparam logic [7:0] E_WRS  = 8'b0000_0000;
    localparam logic [7:0] E_BRT  = 8'b0100_1000;
    localparam logic [7:0] E_BRN  = 8'b1000_1000;
    localparam logic [7:0] E_HALT = 8'b0000_1001;

    typedef struct {
        bit          sel;
        logic [2:0]  st;
        logic [7:0]  en;
        logic [15:0] ret;
        string       tag;
    } exp_t;

    exp_t q[$];
    event check_ev;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input string field, input int act, input int want);
        n_total++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", tag, field, act, want);
        end
    endtask

    always begin
        @(negedge clk or check_ev);
        if (q.size() > 0) begin
            exp_t        e;
            logic [2:0]  st;
            logic [7:0]  en;
            logic [15:0] ret;
            e = q.pop_front();
            if (e.sel) begin
                st  = state_out0;
                en  = {pc_enable0, pc_load0, ir_enable0, r_enable0, alu_bus_enable0, reg_read0, mem_we0, halted0};
                ret = {12'd0, retired_count0};
            end else begin
                st  = state_out;
                en  = {pc_enable, pc_load, ir_enable, r_enable, alu_bus_enable, reg_read, mem_we, halted};
                ret = retired_count;
            end
            chk(e.tag, "state", int'(st), int'(e.st));
            chk(e.tag, "enables", int'(en), int'(e.en));
            chk(e.tag, "retired", int'(ret), int'(e.ret));
            $display("cycle %s: state=%0d en=%b retired=%0d", e.tag, st, en, ret);
        end
    end

    task automatic push(input bit sel, input logic [2:0] st, input logic [7:0] en,
                        input logic [15:0] ret, input string tag);
        exp_t e;
        e.sel = sel; e.st = st; e.en = en; e.ret = ret; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic cyc(input bit sel, input logic [2:0] st, input logic [7:0] en,
                       input logic [15:0] ret, input string tag);
        push(sel, st, en, ret, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset0 = 1'b1;
        op_class = 2'b00; branch_taken = 1'b0; halt = 1'b0; stall = 1'b0;
        op_class0 = 2'b00; branch_taken0 = 1'b0; halt0 = 1'b0; stall0 = 1'b0;
        @(posedge clk); #1;
        cyc(0, 3'd0, E_FW,  16'd0, "rst_state");
        cyc(1, 3'd0, E_FIR, 16'd0, "rst0_state");

        // ALU at latency 2: 5 cycles
        reset = 1'b0;
        op_class = 2'b00;
        cyc(0, 3'd0, E_FW,   16'd0, "alu_f0");
        cyc(0, 3'd0, E_FW,   16'd0, "alu_f1");
        cyc(0, 3'd0, E_FIR,  16'd0, "alu_f2");
        cyc(0, 3'd1, E_DEC,  16'd0, "alu_dec");
        cyc(0, 3'd2, E_EXEC, 16'd0, "alu_exec");

        // Load: 8 cycles
        op_class = 2'b01;
        cyc(0, 3'd0, E_FW,  16'd1, "ld_f0");
        cyc(0, 3'd0, E_FW,  16'd1, "ld_f1");
        cyc(0, 3'd0, E_FIR, 16'd1, "ld_f2");
        cyc(0, 3'd1, E_DEC, 16'd1, "ld_dec");
        cyc(0, 3'd3, E_RD,  16'd1, "ld_rd0");
        cyc(0, 3'd3, E_RD,  16'd1, "ld_rd1");
        cyc(0, 3'd3, E_RD,  16'd1, "ld_rd2");
        cyc(0, 3'd4, E_WB,  16'd1, "ld_wb");

        // Branch taken, then not taken
        op_class = 2'b11; branch_taken = 1'b1;
        cyc(0, 3'd0, E_FW,  16'd2, "brt_f0");
        cyc(0, 3'd0, E_FW,  16'd2, "brt_f1");
        cyc(0, 3'd0, E_FIR, 16'd2, "brt_f2");
        cyc(0, 3'd1, E_DEC, 16'd2, "brt_dec");
        cyc(0, 3'd6, E_BRT, 16'd2, "brt_br");
        branch_taken = 1'b0;
        cyc(0, 3'd0, E_FW,  16'd3, "brn_f0");
        cyc(0, 3'd0, E_FW,  16'd3, "brn_f1");
        cyc(0, 3'd0, E_FIR, 16'd3, "brn_f2");
        cyc(0, 3'd1, E_DEC, 16'd3, "brn_dec");
        cyc(0, 3'd6, E_BRN, 16'd3, "brn_br");

        // Store with a stall mid-fetch and a 4-cycle stall in MEM_WR
        op_class = 2'b10;
        cyc(0, 3'd0, E_FW,  16'd4, "st_f0");
        stall = 1'b1;
        cyc(0, 3'd0, E_FW,  16'd4, "st_fstall0");
        cyc(0, 3'd0, E_FW,  16'd4, "st_fstall1");
        stall = 1'b0;
        cyc(0, 3'd0, E_FW,  16'd4, "st_f1");
        cyc(0, 3'd0, E_FIR, 16'd4, "st_f2");
        cyc(0, 3'd1, E_DEC, 16'd4, "st_dec");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 3'd5, E_WRS, 16'd4, "st_wrstall");
        stall = 1'b0;
        cyc(0, 3'd5, E_WR,  16'd4, "st_wr");

        // Halt, then asynchronous reset while halted
        op_class = 2'b00;
        cyc(0, 3'd0, E_FW,  16'd5, "h_f0");
        cyc(0, 3'd0, E_FW,  16'd5, "h_f1");
        cyc(0, 3'd0, E_FIR, 16'd5, "h_f2");
        halt = 1'b1;
        cyc(0, 3'd1, E_DEC, 16'd5, "h_dec");
        halt = 1'b0; op_class = 2'b01;
        cyc(0, 3'd7, E_HALT, 16'd5, "halt0");
        stall = 1'b1;
        cyc(0, 3'd7, E_HALT, 16'd5, "halt_stall");
        stall = 1'b0; op_class = 2'b10;
        cyc(0, 3'd7, E_HALT, 16'd5, "halt1");
        cyc(0, 3'd7, E_HALT, 16'd5, "halt2");
        #2 reset = 1'b1;
        #1 push(0, 3'd0, E_FW, 16'd0, "rst_in_halt");
        -> check_ev;
        @(posedge clk); #1;
        reset = 1'b0;

        // Store aborted by reset inside MEM_WR: strobe drops without a clock edge
        cyc(0, 3'd0, E_FW,  16'd0, "sr_f0");
        cyc(0, 3'd0, E_FW,  16'd0, "sr_f1");
        cyc(0, 3'd0, E_FIR, 16'd0, "sr_f2");
        cyc(0, 3'd1, E_DEC, 16'd0, "sr_dec");
        push(0, 3'd5, E_WR, 16'd0, "sr_wr");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 push(0, 3'd0, E_FW, 16'd0, "rst_in_wr");
        -> check_ev;
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(0, 3'd0, E_FW, 16'd0, "after_rst");

        // Latency 0, 4-bit counter: 17 ALU instructions wrap to 1
        reset0 = 1'b0;
        for (int n = 0; n < 17; n++) begin
            cyc(1, 3'd0, E_FIR,  16'(n % 16), "w_f");
            cyc(1, 3'd1, E_DEC,  16'(n % 16), "w_dec");
            cyc(1, 3'd2, E_EXEC, 16'(n % 16), "w_exec");
        end
        cyc(1, 3'd0, E_FIR, 16'd1, "wrap_end");

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL queue_drain: got %0d entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
